// File: rtl/control_recorder_pkg.sv
// Shared definitions for the control recorder and the playback path:
// FSM encoding and the bit positions of the fields inside an entry.
package control_recorder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        DONE = 2'd2
    } rec_state_t;

    localparam int ENTRY_W  = 8;
    localparam int SW_LSB   = 0;
    localparam int SW_W     = 3;
    localparam int KEY1_BIT = 3;
    localparam int KEY0_BIT = 4;

    // Bits above KEY0_BIT stay zero so playback can treat them as reserved.
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [SW_W-1:0] sw,
                                                      input logic [1:0]      key);
        logic [ENTRY_W-1:0] e;
        e                 = '0;
        e[SW_LSB +: SW_W] = sw;
        e[KEY1_BIT]       = key[1];
        e[KEY0_BIT]       = key[0];
        return e;
    endfunction

endpackage

// File: rtl/recorder_ram.sv
// DEPTH x 8 entry store: one write port, one registered read port
// (read-before-write on a collision), cleared to zero by reset.
module recorder_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_q
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (we) begin
                mem[wr_addr] <= wr_data;
            end
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/control_recorder.sv
// Records switch/key snapshots on sample_tick into a small RAM for playback.
// Optional RECORD_ON_CHANGE_EN: only store a tick's entry when it differs from the last stored one.
module control_recorder
    import control_recorder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          ADC_CLK_10,
    input  logic          reset_n,
    input  logic          sample_tick,
    input  logic          rec_start,
    input  logic          rec_stop,
    input  logic [2:0]    sw_in,
    input  logic [1:0]    key_in,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW:0]   wr_count,
    output logic          recording,
    output logic          full
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

    rec_state_t  state_reg, state_next;
    logic        start_prev_reg, stop_prev_reg;
    logic [AW:0] wr_count_reg;
    logic        rd_valid_reg;
    logic [7:0]  ram_q;
    logic [7:0]  entry;
    logic        start_edge, stop_edge;
    logic        changed;
    logic        wr_en;

    assign entry      = pack_entry(sw_in, key_in);
    assign start_edge = rec_start & ~start_prev_reg;
    assign stop_edge  = rec_stop & ~stop_prev_reg;

`ifdef RECORD_ON_CHANGE_EN
    logic [7:0] last_entry_reg;

    always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
        if (!reset_n) begin
            last_entry_reg <= '0;
        end else if (wr_en) begin
            last_entry_reg <= entry;
        end
    end

    // The count is only zero in REC right after a start, so the first tick always stores.
    assign changed = (wr_count_reg == '0) || (entry != last_entry_reg);
`else
    assign changed = 1'b1;
`endif

    always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            start_prev_reg <= 1'b0;
            stop_prev_reg  <= 1'b0;
            wr_count_reg   <= '0;
            rd_valid_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_prev_reg <= rec_start;
            stop_prev_reg  <= rec_stop;
            if (start_edge) begin
                wr_count_reg <= '0;
            end else if (wr_en) begin
                wr_count_reg <= wr_count_reg + (AW+1)'(1);
            end
            rd_valid_reg <= ({1'b0, rd_addr} < wr_count_reg);
        end
    end

    always_comb begin
        state_next = state_reg;
        if (start_edge) begin
            state_next = REC;
        end else if (state_reg == REC) begin
            if (stop_edge || (wr_en && wr_count_reg == LAST_CNT)) begin
                state_next = DONE;
            end
        end
    end

    // Start and stop edges both suppress a coincident tick's write.
    always_comb begin
        recording = (state_reg == REC);
        wr_en     = (state_reg == REC) && sample_tick && !start_edge && !stop_edge && changed;
    end

    recorder_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (ADC_CLK_10),
        .rst_n   (reset_n),
        .we      (wr_en),
        .wr_addr (wr_count_reg[AW-1:0]),
        .wr_data (entry),
        .rd_addr (rd_addr),
        .rd_q    (ram_q)
    );

    assign rd_data  = rd_valid_reg ? ram_q : 8'h00;
    assign wr_count = wr_count_reg;
    assign full     = (wr_count_reg == FULL_CNT);

endmodule

// File: tb/tb_control_recorder.sv
// Directed bench for control_recorder: a vector table for the single-cycle
// behaviour plus hand sequences for fill-to-full, restart and async reset.
module tb_control_recorder;

    logic       clk;
    logic       reset_n;
    logic       sample_tick;
    logic       rec_start;
    logic       rec_stop;
    logic [2:0] sw_in;
    logic [1:0] key_in;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic [3:0] wr_count;
    logic       recording;
    logic       full;

    int total = 0;
    int bad   = 0;

    control_recorder #(.DEPTH(8), .AW(3)) dut (
        .ADC_CLK_10  (clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .rec_start   (rec_start),
        .rec_stop    (rec_stop),
        .sw_in       (sw_in),
        .key_in      (key_in),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_count    (wr_count),
        .recording   (recording),
        .full        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       tick;
        logic [2:0] sw;
        logic [1:0] key;
        logic [2:0] addr;
        logic [3:0] cnt;
        logic       rec;
        logic       full;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic s, input logic p, input logic t,
                       input logic [2:0] sw, input logic [1:0] k, input logic [2:0] a);
        @(negedge clk);
        rec_start   = s;
        rec_stop    = p;
        sample_tick = t;
        sw_in       = sw;
        key_in      = k;
        rd_addr     = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        rec_start   = 1'b0;
        rec_stop    = 1'b0;
        sample_tick = 1'b0;
        sw_in       = '0;
        key_in      = '0;
        rd_addr     = '0;
        #1;
        chk("reset_cnt",  32'(wr_count),  32'd0);
        chk("reset_rec",  32'(recording), 32'd0);
        chk("reset_full", 32'(full),      32'd0);
        chk("reset_rd",   32'(rd_data),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(0, 0, 0, 3'd0, 2'd0, 3'd0);
        chk("idle_rec", 32'(recording), 32'd0);

`ifndef RECORD_ON_CHANGE_EN
        //            start stop tick sw      key    addr  cnt  rec full rd
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 3'd0, 4'd0, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 3'b101, 2'b10, 3'd0, 4'd1, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 3'b101, 2'b10, 3'd0, 4'd2, 1'b1, 1'b0, 8'h0D};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 3'b101, 2'b10, 3'd1, 4'd3, 1'b1, 1'b0, 8'h0D};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 3'b101, 2'b10, 3'd2, 4'd3, 1'b1, 1'b0, 8'h0D};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 3'b101, 2'b10, 3'd3, 4'd3, 1'b1, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 3'b101, 2'b10, 3'd0, 4'd3, 1'b1, 1'b0, 8'h0D};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 3'b010, 2'b01, 3'd3, 4'd3, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 3'b010, 2'b01, 3'd0, 4'd3, 1'b0, 1'b0, 8'h0D};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'b010, 2'b01, 3'd0, 4'd0, 1'b1, 1'b0, 8'h0D};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 3'b010, 2'b01, 3'd0, 4'd1, 1'b1, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 3'b111, 2'b11, 3'd0, 4'd2, 1'b1, 1'b0, 8'h12};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 3'b111, 2'b11, 3'd1, 4'd2, 1'b0, 1'b0, 8'h1F};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 3'b111, 2'b11, 3'd2, 4'd2, 1'b0, 1'b0, 8'h00};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 3'b111, 2'b11, 3'd0, 4'd0, 1'b1, 1'b0, 8'h12};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 3'd0, 4'd0, 1'b1, 1'b0, 8'h00};

        for (int v = 0; v < 16; v++) begin
            cyc(vecs[v].start, vecs[v].stop, vecs[v].tick, vecs[v].sw, vecs[v].key, vecs[v].addr);
            $display("vec %0d: cnt=%0d rec=%0b full=%0b rd=%02h", v, wr_count, recording, full, rd_data);
            chk($sformatf("vec%0d_cnt",  v), 32'(wr_count),  32'(vecs[v].cnt));
            chk($sformatf("vec%0d_rec",  v), 32'(recording), 32'(vecs[v].rec));
            chk($sformatf("vec%0d_full", v), 32'(full),      32'(vecs[v].full));
            chk($sformatf("vec%0d_rd",   v), 32'(rd_data),   32'(vecs[v].rd));
        end
`else
        // Four identical ticks store once, a changed fifth tick stores again.
        cyc(1, 0, 0, 3'd3, 2'd3, 3'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 3'd3, 2'd3, 3'd0);
        cyc(0, 0, 1, 3'd5, 2'd3, 3'd0);
        $display("on-change: cnt=%0d", wr_count);
        chk("onchange_cnt", 32'(wr_count), 32'd2);
        cyc(0, 0, 0, 3'd0, 2'd0, 3'd0);
`endif

        // Fill to full with distinct entries; the extra ticks must not wrap onto entry 0.
        cyc(1, 0, 0, 3'd0, 2'd0, 3'd0);
        for (int i = 0; i < 10; i++) begin
            logic [2:0] s;
            logic [1:0] k;
            s = 3'(i);
            k = (i < 8) ? 2'b11 : 2'b00;
            cyc(0, 0, 1, s, k, 3'd0);
            $display("fill tick %0d: cnt=%0d full=%0b rec=%0b", i, wr_count, full, recording);
            chk($sformatf("fill%0d_cnt", i), 32'(wr_count), (i < 8) ? 32'(i + 1) : 32'd8);
            chk($sformatf("fill%0d_full", i), 32'(full), (i >= 7) ? 32'd1 : 32'd0);
        end
        chk("fill_rec", 32'(recording), 32'd0);
        for (int a = 0; a < 8; a++) begin
            cyc(0, 0, 0, 3'd0, 2'd0, 3'(a));
            $display("readback addr %0d: rd=%02h", a, rd_data);
            chk($sformatf("fill_rd%0d", a), 32'(rd_data), 32'h18 | 32'(a));
        end

        // Record four entries, then restart: the old data is masked by the cleared count.
        cyc(1, 0, 0, 3'd0, 2'd0, 3'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 3'(i + 4), 2'b00, 3'd0);
        cyc(0, 0, 0, 3'd0, 2'd0, 3'd3);
        chk("restart_pre_rd", 32'(rd_data), 32'h07);
        cyc(1, 0, 0, 3'd0, 2'd0, 3'd3);
        cyc(0, 0, 0, 3'd0, 2'd0, 3'd3);
        $display("restart: cnt=%0d rd=%02h", wr_count, rd_data);
        chk("restart_cnt", 32'(wr_count), 32'd0);
        chk("restart_rd",  32'(rd_data),  32'h00);

        // Five writes, then pull reset between clock edges.
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 3'(i + 1), 2'b01, 3'd0);
        chk("pre_reset_cnt", 32'(wr_count), 32'd5);
        chk("pre_reset_rd",  32'(rd_data),  32'h11);
        #2;
        reset_n = 1'b0;
        #1;
        $display("async reset: cnt=%0d rec=%0b full=%0b rd=%02h", wr_count, recording, full, rd_data);
        chk("areset_cnt",  32'(wr_count),  32'd0);
        chk("areset_rec",  32'(recording), 32'd0);
        chk("areset_full", 32'(full),      32'd0);
        chk("areset_rd",   32'(rd_data),   32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(0, 0, 1, 3'd7, 2'd3, 3'd0);
        chk("post_reset_cnt", 32'(wr_count),  32'd0);
        chk("post_reset_rec", 32'(recording), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
